// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit : program-counter generator for the fetch stage
//
// Produces the registered fetch address every cycle. The next PC is chosen by
// priority: trap > redirect > stall > call/return > sequential. A small
// circular return-address stack (RAS) predicts return targets. Redirect and
// call targets that are not aligned are diverted to the trap vector.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active-low (0 = reset)
//   we            in   PC write enable; 0 holds PC and RAS (stall)
//   trap          in   take trap: jump to TRAP_VEC and empty the RAS
//   redirect      in   branch/jump resolved in execute
//   redirect_pc   in   redirect target
//   call          in   current pc_out is a call
//   call_target   in   call destination
//   ret           in   current pc_out is a return
//   pc_out        out  current fetch PC (registered)
//   ras_count     out  number of valid RAS entries
//   misalign_err  out  one-cycle pulse when a misaligned target was trapped
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned           XLEN       = 32,
    parameter logic [XLEN-1:0]       RESET_VEC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]       TRAP_VEC   = 32'h0000_0100,
    parameter int unsigned           INC        = 4,
    parameter int unsigned           ALIGN_BITS = 2,
    parameter int unsigned           RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic                           trap,
    input  logic                           redirect,
    input  logic [XLEN-1:0]                redirect_pc,
    input  logic                           call,
    input  logic [XLEN-1:0]                call_target,
    input  logic                           ret,
    output logic [XLEN-1:0]                pc_out,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           misalign_err
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Ones in the low ALIGN_BITS positions; all-zero when the check is disabled,
    // so every address is then considered aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic aligned_f(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK) == '0;
    endfunction

    // Count after a push: saturates at the depth, because a push into a full
    // stack overwrites the oldest entry instead of growing.
    function automatic logic [CNT_W-1:0] cnt_push_f(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q,  pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;

    // RAS storage carries data only; its contents are meaningless while the
    // count is zero, so it is never reset.
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    logic             push_en;
    logic [XLEN-1:0]  push_data;

    logic [XLEN-1:0]  seq_pc;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [XLEN-1:0]  ras_top;

    // Sequential successor wraps modulo 2^XLEN.
    assign seq_pc  = pc_q + XLEN'(INC);

    // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
    assign ptr_inc = ptr_q + 1'b1;
    assign ptr_dec = ptr_q - 1'b1;
    assign ras_top = ras_q[ptr_dec];

    // -----------------------------------------------------------------------
    // Next-state selection
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        err_d     = 1'b0;
        push_en   = 1'b0;
        push_data = seq_pc;

        if (trap) begin
            pc_d  = TRAP_VEC;
            cnt_d = '0;
            ptr_d = '0;
        end else if (redirect) begin
            if (aligned_f(redirect_pc)) begin
                // Redirect does not touch the RAS.
                pc_d = redirect_pc;
            end else begin
                pc_d  = TRAP_VEC;
                err_d = 1'b1;
                cnt_d = '0;
                ptr_d = '0;
            end
        end else if (!we) begin
            // Stall: hold everything, call/ret are ignored.
            pc_d = pc_q;
        end else if (call) begin
            // A call takes precedence over a simultaneous ret.
            if (aligned_f(call_target)) begin
                pc_d      = call_target;
                push_en   = 1'b1;
                push_data = seq_pc;
                ptr_d     = ptr_inc;
                cnt_d     = cnt_push_f(cnt_q);
            end else begin
                pc_d  = TRAP_VEC;
                err_d = 1'b1;
                cnt_d = '0;
                ptr_d = '0;
            end
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_top;
                ptr_d = ptr_dec;
                cnt_d = cnt_q - 1'b1;
            end else begin
                // Empty stack: no prediction available, fall through.
                pc_d = seq_pc;
            end
        end else begin
            pc_d = seq_pc;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // RAS storage: written only on an accepted push outside reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && push_en) begin
            ras_q[ptr_q] <= push_data;
        end
    end

    assign pc_out       = pc_q;
    assign ras_count    = cnt_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        trap;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        call;
    logic [31:0] call_target;
    logic        ret;
    logic [31:0] pc_out;
    logic [2:0]  ras_count;
    logic        misalign_err;

    pc_unit #(
        .XLEN(32), .RESET_VEC(32'h0000_0000), .TRAP_VEC(32'h0000_0100),
        .INC(4), .ALIGN_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .trap(trap), .redirect(redirect),
        .redirect_pc(redirect_pc), .call(call), .call_target(call_target),
        .ret(ret), .pc_out(pc_out), .ras_count(ras_count),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;

    // Monitor: every clock edge produces a new output; the expectation for it
    // was queued by the stimulus before that edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (pc_out !== e.pc) begin
                bad++;
                $display("FAIL pc[v%0d]: got %h expected %h", e.id, pc_out, e.pc);
            end
            total++;
            if (ras_count !== e.cnt) begin
                bad++;
                $display("FAIL ras_count[v%0d]: got %0d expected %0d", e.id, ras_count, e.cnt);
            end
            total++;
            if (misalign_err !== e.err) begin
                bad++;
                $display("FAIL misalign_err[v%0d]: got %b expected %b", e.id, misalign_err, e.err);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic w, input logic t,
                        input logic rd, input logic [31:0] rpc,
                        input logic c, input logic [31:0] ct, input logic rt,
                        input logic [31:0] epc, input logic [2:0] ecnt, input logic eerr);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; trap = t; redirect = rd; redirect_pc = rpc;
        call = c; call_target = ct; ret = rt;
        e.id = vec_id; e.pc = epc; e.cnt = ecnt; e.err = eerr;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Shorthands for common cycles
    task automatic seq(input logic [31:0] epc, input logic [2:0] ecnt);
        step(1, 1, 0, 0, 0, 0, 0, 0, epc, ecnt, 0);
    endtask
    task automatic do_call(input logic [31:0] tgt, input logic [31:0] epc,
                           input logic [2:0] ecnt, input logic eerr);
        step(1, 1, 0, 0, 0, 1, tgt, 0, epc, ecnt, eerr);
    endtask
    task automatic do_ret(input logic [31:0] epc, input logic [2:0] ecnt);
        step(1, 1, 0, 0, 0, 0, 0, 1, epc, ecnt, 0);
    endtask
    task automatic do_redir(input logic [31:0] tgt, input logic [31:0] epc,
                            input logic [2:0] ecnt, input logic eerr);
        step(1, 1, 0, 1, tgt, 0, 0, 0, epc, ecnt, eerr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; we = 1; trap = 0; redirect = 0; redirect_pc = 0;
        call = 0; call_target = 0; ret = 0;

        // Reset then sequential fetch
        step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        seq(32'h4, 0);
        seq(32'h8, 0);
        seq(32'hC, 0);

        // Stall holds, redirect overrides stall
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 0);
        seq(32'h10, 0);
        step(1, 0, 0, 1, 32'h40, 0, 0, 0, 32'h40, 0, 0);
        do_redir(32'h10, 32'h10, 0, 0);

        // Call / return, return on empty stack, call ignored while stalled
        do_call(32'h200, 32'h200, 1, 0);
        seq(32'h204, 1);
        do_ret(32'h14, 0);
        do_ret(32'h18, 0);
        step(1, 0, 0, 0, 0, 1, 32'h500, 0, 32'h18, 0, 0);

        // Nested calls overflow a depth-4 stack: A4 is overwritten
        do_redir(32'hA0, 32'hA0, 0, 0);
        do_call(32'hB0, 32'hB0, 1, 0);
        do_call(32'hC0, 32'hC0, 2, 0);
        do_call(32'hD0, 32'hD0, 3, 0);
        do_call(32'hE0, 32'hE0, 4, 0);
        do_call(32'hF0, 32'hF0, 4, 0);
        do_ret(32'hE4, 3);
        do_ret(32'hD4, 2);
        do_ret(32'hC4, 1);
        do_ret(32'hB4, 0);
        do_ret(32'hB8, 0);

        // call and ret together: call wins
        step(1, 1, 0, 0, 0, 1, 32'h240, 1, 32'h240, 1, 0);
        do_ret(32'hBC, 0);

        // Redirect beats call; misaligned redirect traps and empties the RAS
        do_call(32'h280, 32'h280, 1, 0);
        step(1, 1, 0, 1, 32'h300, 1, 32'h600, 0, 32'h300, 1, 0);
        do_redir(32'h302, 32'h100, 0, 1);
        seq(32'h104, 0);

        // Misaligned call target traps the same way
        do_call(32'h400, 32'h400, 1, 0);
        do_call(32'h206, 32'h100, 0, 1);
        seq(32'h104, 0);

        // Trap beats redirect and call, empties a 3-deep stack
        do_call(32'h500, 32'h500, 1, 0);
        do_call(32'h600, 32'h600, 2, 0);
        do_call(32'h700, 32'h700, 3, 0);
        step(1, 1, 1, 1, 32'h800, 1, 32'h900, 0, 32'h100, 0, 0);
        do_ret(32'h104, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0);

        // Reset mid-operation overrides trap/call and empties the RAS
        seq(32'h104, 0);
        do_call(32'h900, 32'h900, 1, 0);
        step(0, 1, 1, 0, 0, 1, 32'hA00, 0, 32'h0, 0, 0);
        do_ret(32'h4, 0);

        // Sequential wrap-around at the top of the address space
        do_redir(32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
        seq(32'h0, 0);

        // Drain the scoreboard
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
